hnf_biq_cam: RTL

Second-generation HN-F back-invalidation queue. It is an in-order address FIFO with a cache-block-granular CAM search, and sits between the HN-F snoop-filter eviction path and the back-invalidation snoop issue logic. Compared with the first-generation queue, it adds:
- valid/ready handshakes on both sides;
- non-power-of-two depth;
- an occupancy count and a programmable almost-full threshold;
- a search result that reports the matching slot's position;
- optional push-time duplicate suppression.

---
 rtl/hnf_biq_pkg.sv | 15 +
 rtl/hnf_biq_cam_match.sv | 29 ++
 rtl/hnf_biq_cam.sv | 94 +++++++++
 3 files changed

// File: rtl/hnf_biq_pkg.sv
// hnf_biq_pkg: shared sizing and index helpers for the back-invalidation queue
package hnf_biq_pkg;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
  function automatic logic [63:0] blk_addr(input logic [63:0] addr, input int off);
    return addr >> off;
  endfunction
  function automatic int wrap_inc(input int idx, input int depth);
    return (idx == depth - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/hnf_biq_cam_match.sv
// hnf_biq_cam_match: block-granular compare of a key against all valid entries
module hnf_biq_cam_match
  import hnf_biq_pkg::*;
#(
  parameter int W   = 44,
  parameter int D   = 6,
  parameter int OFF = 6,
  parameter int CW  = cnt_w(D),
  parameter int IW  = idx_w(D)
) (
  input  logic [W-1:0]  data_i [D],
  input  logic [D-1:0]  vld_i,
  input  logic [IW-1:0] head_i,
  input  logic [W-1:0]  key_i,
  output logic [D-1:0]  match_o,
  output logic          hit_o,
  output logic [CW-1:0] pos_o
);
  always_comb begin
    match_o = '0;
    pos_o   = '0;
    for (int i = 0; i < D; i++)
      match_o[i] = vld_i[i] && (blk_addr(64'(data_i[i]), OFF) == blk_addr(64'(key_i), OFF));
    // walk from youngest to oldest so the oldest match wins
    for (int k = D - 1; k >= 0; k--)
      if (match_o[IW'((int'(head_i) + k) % D)]) pos_o = CW'(k);
  end
  assign hit_o = |match_o;
endmodule

// File: rtl/hnf_biq_cam.sv
// hnf_biq_cam: in-order HN-F back-invalidation address FIFO with CAM search and dedup
module hnf_biq_cam
  import hnf_biq_pkg::*;
#(
  parameter int BIQ_WIDTH    = 44,
  parameter int BIQ_DEPTH    = 6,
  parameter int BLK_OFFSET   = 6,
  parameter int PFULL_THRESH = BIQ_DEPTH - 1,
  parameter int DEDUP_EN     = 1,
  localparam int CNT_W       = cnt_w(BIQ_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_valid,
  output logic                 push_ready,
  input  logic [BIQ_WIDTH-1:0] push_addr,
  output logic                 pop_valid,
  input  logic                 pop_ready,
  output logic [BIQ_WIDTH-1:0] pop_addr,
  input  logic                 find,
  input  logic [BIQ_WIDTH-1:0] find_addr,
  output logic                 find_hit,
  output logic [CNT_W-1:0]     find_pos,
  output logic                 push_dup,
  output logic [CNT_W-1:0]     biq_count,
  output logic                 biq_full,
  output logic                 biq_empty,
  output logic                 biq_pfull
);
  localparam int IDX_W = idx_w(BIQ_DEPTH);
  logic [BIQ_WIDTH-1:0] data_q [BIQ_DEPTH];
  logic [IDX_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 dup_q, dup_d;
  logic [BIQ_DEPTH-1:0] vld, dvld, f_match, d_match;
  logic [CNT_W-1:0]     f_pos, d_pos;
  logic                 f_hit, d_hit, pop_fire, push_fire, dup, wr;
  logic                 unused_ok;
  assign biq_count  = cnt_q;
  assign biq_empty  = cnt_q == '0;
  assign biq_full   = cnt_q == CNT_W'(BIQ_DEPTH);
  assign biq_pfull  = cnt_q >= CNT_W'(PFULL_THRESH);
  assign pop_valid  = !biq_empty;
  assign pop_addr   = data_q[head_q];
  assign pop_fire   = pop_valid && pop_ready;
  assign push_ready = !biq_full || pop_ready;
  assign push_fire  = push_valid && push_ready;
  assign push_dup   = dup_q;
  always_comb begin
    vld = '0;
    for (int i = 0; i < BIQ_DEPTH; i++)
      vld[i] = ((i >= int'(head_q)) ? i - int'(head_q) : i + BIQ_DEPTH - int'(head_q)) < int'(cnt_q);
  end
  // the head leaving this cycle must not make a fresh copy of its block look redundant
  assign dvld = vld & ~(pop_fire ? (BIQ_DEPTH'(1) << head_q) : '0);
  hnf_biq_cam_match #(.W(BIQ_WIDTH), .D(BIQ_DEPTH), .OFF(BLK_OFFSET)) u_find (
    .data_i(data_q), .vld_i(vld), .head_i(head_q), .key_i(find_addr),
    .match_o(f_match), .hit_o(f_hit), .pos_o(f_pos)
  );
  hnf_biq_cam_match #(.W(BIQ_WIDTH), .D(BIQ_DEPTH), .OFF(BLK_OFFSET)) u_dedup (
    .data_i(data_q), .vld_i(dvld), .head_i(head_q), .key_i(push_addr),
    .match_o(d_match), .hit_o(d_hit), .pos_o(d_pos)
  );
  assign unused_ok = ^{f_match, d_match, d_pos};
  assign find_hit  = find && f_hit;
  assign find_pos  = find_hit ? f_pos : '0;
  assign dup       = (DEDUP_EN != 0) && push_fire && d_hit;
  assign wr        = push_fire && !dup;
  always_comb begin
    head_d = pop_fire ? IDX_W'(wrap_inc(int'(head_q), BIQ_DEPTH)) : head_q;
    tail_d = wr ? IDX_W'(wrap_inc(int'(tail_q), BIQ_DEPTH)) : tail_q;
    cnt_d  = cnt_q + CNT_W'(wr) - CNT_W'(pop_fire);
    dup_d  = dup;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      dup_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      dup_q  <= dup_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) data_q[tail_q] <= push_addr;
  end
  always @(posedge clk) begin
    if (!rst) assert (!(pop_ready && !pop_valid)) else $warning("hnf_biq_cam: pop_ready while empty");
  end
endmodule
